// File: rtl/niosmp_oci_trace_capture.sv
// niosmp_oci_trace_capture: captures debug-trace words into a FWFT FIFO and sequences
// the capture/flush/done lifecycle around simulation end.
module niosmp_oci_trace_capture #(
    parameter int DATA_W = 30,
    parameter int CNT_W = 4,
    parameter int DEPTH = 16,
    parameter int WRAP_MODE = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dct_valid,
    input  logic [DATA_W-1:0]         dct_buffer,
    input  logic [CNT_W-1:0]          dct_count,
    input  logic                      test_ending,
    input  logic                      test_has_ended,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [CNT_W+DATA_W-1:0]   out_data,
    output logic [$clog2(DEPTH):0]    fill_level,
    output logic [31:0]               frame_total,
    output logic [15:0]               overflow_count,
    output logic [1:0]                state,
    output logic                      done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;
    state_t st, st_nxt;
    logic [CNT_W+DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] fill;
    logic ended, accept, pop, full, push, lost, evict, fin, drained;
    logic [32:0] ft_sum;
    always_comb begin
        accept = dct_valid && dct_count != '0 && (st == IDLE || st == CAPTURE);
        pop = fill != '0 && out_ready;
        full = fill == FULL;
        lost = accept && full && !pop;
        evict = lost && WRAP_MODE != 0;
        push = accept && (!lost || evict);
        fin = test_ending || test_has_ended;
        drained = fill == '0 || (fill == (AW+1)'(1) && pop);
        ft_sum = {1'b0, frame_total} + 33'(dct_count);
        st_nxt = st == IDLE    ? (fin ? FLUSH : accept ? CAPTURE : IDLE) :
                 st == CAPTURE ? (fin ? FLUSH : CAPTURE) :
                 st == FLUSH   ? (drained && (ended || test_has_ended) ? DONE : FLUSH) :
                                 DONE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            st <= IDLE;
            wptr <= '0;
            rptr <= '0;
            fill <= '0;
            frame_total <= '0;
            overflow_count <= '0;
            ended <= 1'b0;
        end else begin
            st <= st_nxt;
            ended <= ended | test_has_ended;
            if (push) wptr <= wptr + 1'b1;
            if (pop || evict) rptr <= rptr + 1'b1;
            fill <= fill + (AW+1)'(push) - (AW+1)'(pop || evict);
            if (accept) frame_total <= ft_sum[32] ? '1 : ft_sum[31:0];
            if (lost && overflow_count != '1) overflow_count <= overflow_count + 1'b1;
        end
    end
    // Storage needs no reset: out_data is gated by out_valid, so stale entries never show.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {dct_count, dct_buffer};
    end
    assign out_valid = fill != '0;
    assign out_data = out_valid ? mem[rptr] : '0;
    assign fill_level = fill;
    assign state = st;
    assign done = st == DONE;
endmodule
